// File: rtl/ahb_lite_decode_mux.sv
// 1-master / N-slave AHB-Lite decoder and response mux with a built-in default slave.
// Unmapped NONSEQ/SEQ transfers get a two-cycle ERROR; a saturating counter records them.
module ahb_lite_decode_mux #(
    parameter int NUM_SLAVES    = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEC_LSB       = 28,
    parameter int DEC_BITS      = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [ADDR_WIDTH-1:0]            haddr_m0,
    input  logic [1:0]                       htrans_m0,
    input  logic                             hwrite_m0,
    input  logic [2:0]                       hsize_m0,
    input  logic [2:0]                       hburst_m0,
    input  logic [3:0]                       hprot_m0,
    input  logic                             hmastlock_m0,
    input  logic [DATA_WIDTH-1:0]            hwdata_m0,
    output logic                             hready_m0,
    output logic                             hresp_m0,
    output logic [DATA_WIDTH-1:0]            hrdata_m0,
    output logic [NUM_SLAVES-1:0]            hsel_s,
    output logic [ADDR_WIDTH-1:0]            haddr_s,
    output logic [1:0]                       htrans_s,
    output logic                             hwrite_s,
    output logic [2:0]                       hsize_s,
    output logic [2:0]                       hburst_s,
    output logic [3:0]                       hprot_s,
    output logic                             hmastlock_s,
    output logic [DATA_WIDTH-1:0]            hwdata_s,
    output logic                             hready_s,
    input  logic [NUM_SLAVES-1:0]            hreadyout_s,
    input  logic [NUM_SLAVES-1:0]            hresp_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    input  logic                             err_clr,
    output logic [ERR_CNT_WIDTH-1:0]         err_cnt,
    output logic [1:0]                       ds_state_dbg
);

    // Handshake: a transfer's address phase is accepted on a rising edge with
    // hready_m0=1; its data phase completes on the next such edge.

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    localparam int DSEL_W = NUM_SLAVES + 1;
    localparam logic [DSEL_W-1:0] DSEL_DEF = {1'b1, {NUM_SLAVES{1'b0}}};

    ds_state_t                ds_state_q, ds_state_d;
    logic [DSEL_W-1:0]        dsel_q;
    logic [NUM_SLAVES-1:0]    hsel_int;
    logic [DEC_BITS-1:0]      dec;
    logic                     addr_match;
    logic                     unmapped_req;
    logic                     err_entry;
    logic                     ds_hready, ds_hresp;
    logic                     mux_ready, mux_resp;
    logic [DATA_WIDTH-1:0]    mux_rdata;

    assign haddr_s     = haddr_m0;
    assign htrans_s    = htrans_m0;
    assign hwrite_s    = hwrite_m0;
    assign hsize_s     = hsize_m0;
    assign hburst_s    = hburst_m0;
    assign hprot_s     = hprot_m0;
    assign hmastlock_s = hmastlock_m0;
    assign hwdata_s    = hwdata_m0;
    assign hready_s    = hready_m0;

    assign dec = haddr_m0[DEC_LSB +: DEC_BITS];

    always_comb begin
        hsel_int = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hsel_int[i] = (dec == DEC_BITS'(i));
        end
    end

    assign hsel_s       = hsel_int;
    assign addr_match   = |hsel_int;
    assign unmapped_req = hready_m0 & ~addr_match & htrans_m0[1];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q <= DSEL_DEF;
        end else if (hready_m0) begin
            dsel_q <= {~addr_match, hsel_int};
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ds_state_q <= DS_IDLE;
        end else begin
            ds_state_q <= ds_state_d;
        end
    end

    always_comb begin
        ds_state_d = ds_state_q;
        ds_hready  = 1'b1;
        ds_hresp   = 1'b0;
        case (ds_state_q)
            DS_IDLE: begin
                if (unmapped_req) ds_state_d = DS_ERR1;
            end
            DS_ERR1: begin
                ds_hready  = 1'b0;
                ds_hresp   = 1'b1;
                ds_state_d = DS_ERR2;
            end
            DS_ERR2: begin
                ds_hresp   = 1'b1;
                ds_state_d = unmapped_req ? DS_ERR1 : DS_IDLE;
            end
            default: ds_state_d = DS_IDLE;
        endcase
    end

    assign ds_state_dbg = ds_state_q;
    assign err_entry    = (ds_state_d == DS_ERR1);

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (err_entry && (err_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    always_comb begin
        mux_ready = 1'b0;
        mux_resp  = 1'b0;
        mux_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_q[i]) begin
                mux_ready = mux_ready | hreadyout_s[i];
                mux_resp  = mux_resp  | hresp_s[i];
                mux_rdata = mux_rdata | hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (dsel_q[NUM_SLAVES]) begin
            mux_ready = ds_hready;
            mux_resp  = ds_hresp;
            mux_rdata = '0;
        end
    end

    assign hready_m0 = mux_ready;
    assign hresp_m0  = mux_resp;
    assign hrdata_m0 = mux_rdata;

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// Directed bench for ahb_lite_decode_mux: a per-cycle vector table plus hand
// sequences for counter saturation, reset during ERROR and err_clr.
module tb_ahb_lite_decode_mux;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_1111;
    localparam logic [31:0] D2 = 32'h3333_2222;
    localparam logic [31:0] D3 = 32'h4444_3333;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [31:0]  haddr_m0;
    logic [1:0]   htrans_m0;
    logic         hwrite_m0;
    logic [2:0]   hsize_m0;
    logic [2:0]   hburst_m0;
    logic [3:0]   hprot_m0;
    logic         hmastlock_m0;
    logic [31:0]  hwdata_m0;
    logic         hready_m0;
    logic         hresp_m0;
    logic [31:0]  hrdata_m0;
    logic [3:0]   hsel_s;
    logic [31:0]  haddr_s;
    logic [1:0]   htrans_s;
    logic         hwrite_s;
    logic [2:0]   hsize_s;
    logic [2:0]   hburst_s;
    logic [3:0]   hprot_s;
    logic         hmastlock_s;
    logic [31:0]  hwdata_s;
    logic         hready_s;
    logic [3:0]   hreadyout_s;
    logic [3:0]   hresp_s;
    logic [127:0] hrdata_s;
    logic         err_clr;
    logic [3:0]   err_cnt;
    logic [1:0]   ds_state_dbg;

    int total = 0;
    int bad   = 0;

    ahb_lite_decode_mux #(
        .NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .DEC_LSB(28), .DEC_BITS(4), .ERR_CNT_WIDTH(4)
    ) dut (
        .hclk(hclk), .hresetn(hresetn),
        .haddr_m0(haddr_m0), .htrans_m0(htrans_m0), .hwrite_m0(hwrite_m0),
        .hsize_m0(hsize_m0), .hburst_m0(hburst_m0), .hprot_m0(hprot_m0),
        .hmastlock_m0(hmastlock_m0), .hwdata_m0(hwdata_m0),
        .hready_m0(hready_m0), .hresp_m0(hresp_m0), .hrdata_m0(hrdata_m0),
        .hsel_s(hsel_s), .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s),
        .hsize_s(hsize_s), .hburst_s(hburst_s), .hprot_s(hprot_s),
        .hmastlock_s(hmastlock_s), .hwdata_s(hwdata_s), .hready_s(hready_s),
        .hreadyout_s(hreadyout_s), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
        .err_clr(err_clr), .err_cnt(err_cnt), .ds_state_dbg(ds_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 hclk = ~hclk;

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  ryo;
        logic [3:0]  rsp;
        logic        clr;
        logic [3:0]  e_sel;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_rdata;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] trans,
                                input logic wr, input logic [31:0] wdata,
                                input logic [3:0] ryo, input logic [3:0] rsp,
                                input logic clr, input logic [3:0] e_sel,
                                input logic e_rdy, input logic e_resp,
                                input logic [31:0] e_rdata, input logic [3:0] e_cnt);
        vec_t v;
        v.addr = addr; v.trans = trans; v.wr = wr; v.wdata = wdata;
        v.ryo = ryo; v.rsp = rsp; v.clr = clr; v.e_sel = e_sel;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_rdata = e_rdata; v.e_cnt = e_cnt;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [31:0] addr, input logic [1:0] trans,
                         input logic wr, input logic [31:0] wdata,
                         input logic [3:0] ryo, input logic [3:0] rsp, input logic clr);
        haddr_m0    = addr;
        htrans_m0   = trans;
        hwrite_m0   = wr;
        hwdata_m0   = wdata;
        hreadyout_s = ryo;
        hresp_s     = rsp;
        err_clr     = clr;
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #2;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        hresetn      = 1'b0;
        hsize_m0     = 3'b010;
        hburst_m0    = 3'b001;
        hprot_m0     = 4'b0011;
        hmastlock_m0 = 1'b0;
        hrdata_s     = {D3, D2, D1, D0};
        drive(32'h0, 2'd0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);

        vecs[0]  = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 32'h0, 4'd0);
        vecs[1]  = mk(32'h2000_0010, 2'd2, 1'b1, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b0, D0,    4'd0);
        vecs[2]  = mk(32'h0000_0000, 2'd0, 1'b0, 32'hCAFE_0002, 4'hB, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b0, D2,    4'd0);
        vecs[3]  = mk(32'h0000_0000, 2'd0, 1'b0, 32'hCAFE_0002, 4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, D2,    4'd0);
        vecs[4]  = mk(32'h1000_0000, 2'd2, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0010, 1'b1, 1'b0, D0,    4'd0);
        vecs[5]  = mk(32'h3000_0000, 2'd2, 1'b0, 32'h0,         4'hD, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0, D1,    4'd0);
        vecs[6]  = mk(32'h3000_0000, 2'd2, 1'b0, 32'h0,         4'hD, 4'h0, 1'b0, 4'b1000, 1'b0, 1'b0, D1,    4'd0);
        vecs[7]  = mk(32'h3000_0000, 2'd2, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b1000, 1'b1, 1'b0, D1,    4'd0);
        vecs[8]  = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h8, 1'b0, 4'b0001, 1'b1, 1'b1, D3,    4'd0);
        vecs[9]  = mk(32'h7000_0000, 2'd2, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, D0,    4'd0);
        vecs[10] = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h0, 4'd1);
        vecs[11] = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h0, 4'd1);
        vecs[12] = mk(32'h7000_0000, 2'd2, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, D0,    4'd1);
        vecs[13] = mk(32'h7000_0004, 2'd3, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0, 4'd2);
        vecs[14] = mk(32'h7000_0004, 2'd3, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0, 4'd2);
        vecs[15] = mk(32'h7000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h0, 4'd3);
        vecs[16] = mk(32'h7000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h0, 4'd3);
        vecs[17] = mk(32'h7000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0, 4'd3);
        vecs[18] = mk(32'h4000_0000, 2'd1, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0, 4'd3);
        vecs[19] = mk(32'h7000_0000, 2'd2, 1'b0, 32'h0,         4'hF, 4'h0, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h0, 4'd3);
        vecs[20] = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h0, 4'd0);
        vecs[21] = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 32'h0, 4'd0);
        vecs[22] = mk(32'h0000_0000, 2'd0, 1'b0, 32'h0,         4'hF, 4'h0, 1'b0, 4'b0001, 1'b1, 1'b0, D0,    4'd0);

        // Reset state observed while hresetn is still low.
        repeat (2) @(posedge hclk);
        #2;
        chk("rst_hready", 32'(hready_m0), 32'h1);
        chk("rst_hresp",  32'(hresp_m0),  32'h0);
        chk("rst_hrdata", hrdata_m0,      32'h0);
        chk("rst_errcnt", 32'(err_cnt),   32'h0);
        chk("rst_state",  32'(ds_state_dbg), 32'h0);
        hresetn = 1'b1;

        // Table: inputs applied just after an edge, outputs checked before the next.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].addr, vecs[i].trans, vecs[i].wr, vecs[i].wdata,
                  vecs[i].ryo, vecs[i].rsp, vecs[i].clr);
            #2;
            chk($sformatf("v%0d_hsel", i),    32'(hsel_s),    32'(vecs[i].e_sel));
            chk($sformatf("v%0d_hready", i),  32'(hready_m0), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_hready_s", i), 32'(hready_s), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_hresp", i),   32'(hresp_m0),  32'(vecs[i].e_resp));
            chk($sformatf("v%0d_hrdata", i),  hrdata_m0,      vecs[i].e_rdata);
            chk($sformatf("v%0d_errcnt", i),  32'(err_cnt),   32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_haddr_s", i), haddr_s,        vecs[i].addr);
            chk($sformatf("v%0d_htrans_s", i), 32'(htrans_s), 32'(vecs[i].trans));
            chk($sformatf("v%0d_hwrite_s", i), 32'(hwrite_s), 32'(vecs[i].wr));
            chk($sformatf("v%0d_hwdata_s", i), hwdata_s,      vecs[i].wdata);
            chk($sformatf("v%0d_hsize_s", i), 32'(hsize_s),   32'h2);
            chk($sformatf("v%0d_hprot_s", i), 32'(hprot_s),   32'h3);
            next_cycle();
        end

        // 17 back-to-back unmapped NONSEQ errors on a 4-bit counter: saturates at 15.
        drive(32'h7000_0000, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        repeat (34) @(posedge hclk);
        #2;
        chk("sat_errcnt", 32'(err_cnt), 32'd15);
        chk("sat_state",  32'(ds_state_dbg), 32'd2);
        chk("sat_hresp",  32'(hresp_m0),  32'h1);
        chk("sat_hready", 32'(hready_m0), 32'h1);

        // Back to idle, then one more error: counter stays saturated.
        drive(32'h0000_0000, 2'd0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        next_cycle();
        chk("idle_state", 32'(ds_state_dbg), 32'd0);
        drive(32'h7000_0000, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        next_cycle();
        chk("err1_hready", 32'(hready_m0), 32'h0);
        chk("err1_hresp",  32'(hresp_m0),  32'h1);
        chk("err1_errcnt", 32'(err_cnt),   32'd15);

        // Asynchronous reset in the middle of DS_ERR1.
        #1;
        hresetn = 1'b0;
        #1;
        chk("arst_hready", 32'(hready_m0), 32'h1);
        chk("arst_hresp",  32'(hresp_m0),  32'h0);
        chk("arst_hrdata", hrdata_m0,      32'h0);
        chk("arst_errcnt", 32'(err_cnt),   32'h0);
        chk("arst_state",  32'(ds_state_dbg), 32'h0);
        drive(32'h0000_0100, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        next_cycle();
        hresetn = 1'b1;
        chk("post_rst_hsel", 32'(hsel_s), 32'b0001);
        next_cycle();
        drive(32'h0000_0000, 2'd0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        #1;
        chk("post_rst_hready", 32'(hready_m0), 32'h1);
        chk("post_rst_hresp",  32'(hresp_m0),  32'h0);
        chk("post_rst_hrdata", hrdata_m0,      D0);
        chk("post_rst_errcnt", 32'(err_cnt),   32'h0);

        // Standalone err_clr after one counted error.
        #1;
        next_cycle();
        drive(32'h7000_0000, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        next_cycle();
        chk("one_err_cnt", 32'(err_cnt), 32'd1);
        drive(32'h0000_0000, 2'd0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b0);
        repeat (2) next_cycle();
        drive(32'h0000_0000, 2'd0, 1'b0, 32'h0, 4'hF, 4'h0, 1'b1);
        next_cycle();
        err_clr = 1'b0;
        chk("clr_errcnt", 32'(err_cnt), 32'd0);
        chk("clr_state",  32'(ds_state_dbg), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
